// File: rtl/square_draw_arbiter.sv
// Round-robin arbiter that shares one square_drawer between two requesters and
// merges the drawer's pixel stream with the granted colour into a single write port.
module square_draw_arbiter #(
  parameter int SIZE    = 10,
  parameter int CW      = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [10:0]   x0_0,
  input  logic [10:0]   y0_0,
  input  logic [10:0]   x0_1,
  input  logic [10:0]   y0_1,
  input  logic [CW-1:0] col_0,
  input  logic [CW-1:0] col_1,
  output logic [1:0]    ack,
  output logic          err,
  output logic          busy,
  output logic          drw_start,
  output logic [10:0]   drw_x0,
  output logic [10:0]   drw_y0,
  input  logic [10:0]   drw_x,
  input  logic [10:0]   drw_y,
  input  logic          drw_done,
  output logic [10:0]   pix_x,
  output logic [10:0]   pix_y,
  output logic [CW-1:0] pix_col,
  output logic          pix_we
);

  // state   | meaning
  // IDLE    | no job; arbitrate among raised req bits
  // ISSUE   | job latched; raise drawer start, clear watchdog
  // DRAW    | drawer streaming pixels until done or watchdog expiry
  // RELEASE | drop start, ack the served requester, hand over to the other one
  typedef enum logic [1:0] {IDLE, ISSUE, DRAW, RELEASE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  // Drawer coordinates are 11 bits wide, so the square edge must fit too.
  if (SIZE < 0 || SIZE > 2046) begin : g_bad_size
    $error("square_draw_arbiter: SIZE out of range");
  end

  state_t        state, state_nxt;
  logic          last;
  logic          gnt, gnt_nxt;
  logic          grant;
  logic          to_hit, to_flag;
  logic [CW-1:0] col_q;
  logic [TW-1:0] wd_cnt;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant     = 1'b0;
    to_hit    = 1'b0;
    drw_start = 1'b0;
    pix_we    = 1'b0;
    ack       = 2'b00;
    case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          // last==1 favours requester 0, last==0 favours requester 1
          gnt_nxt   = last ? !req[0] : req[1];
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        drw_start = 1'b1;
        state_nxt = DRAW;
      end
      DRAW: begin
        drw_start = 1'b1;
        pix_we    = !drw_done;
        if (drw_done) begin
          state_nxt = RELEASE;
        end else if (wd_cnt == TW'(TIMEOUT)) begin
          to_hit    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        ack       = gnt ? 2'b10 : 2'b01;
        state_nxt = IDLE;
        if (req[!gnt]) begin
          grant     = 1'b1;
          gnt_nxt   = !gnt;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt     <= 1'b0;
      col_q   <= '0;
      drw_x0  <= '0;
      drw_y0  <= '0;
      wd_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      to_flag <= to_hit;
      if (state == RELEASE) last <= gnt;
      if (grant) begin
        drw_x0 <= gnt_nxt ? x0_1 : x0_0;
        drw_y0 <= gnt_nxt ? y0_1 : y0_0;
        col_q  <= gnt_nxt ? col_1 : col_0;
      end
      // Saturating watchdog so a stuck drawer can never wrap it back to zero
      if (state == ISSUE) wd_cnt <= '0;
      else if (state == DRAW && wd_cnt != TW'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign err     = (state == RELEASE) && to_flag;
  assign busy    = (state != IDLE);
  assign pix_x   = drw_x;
  assign pix_y   = drw_y;
  assign pix_col = col_q;

endmodule

// File: tb/tb_square_draw_arbiter.sv
// Directed bench: behavioural square drawer feeding the main arbiter, plus a
// second arbiter with a stuck drawer and a short watchdog.
module tb_square_draw_arbiter;

  localparam int SIZE = 10;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [10:0]   x0_0 = '0, y0_0 = '0, x0_1 = '0, y0_1 = '0;
  logic [CW-1:0] col_0 = '0, col_1 = '0;
  logic [1:0]    ack;
  logic          err, busy, drw_start, pix_we;
  logic [10:0]   drw_x0, drw_y0, pix_x, pix_y;
  logic [CW-1:0] pix_col;

  logic [10:0]   d_x, d_y;
  logic          d_done, d_active;

  logic [1:0]    req_wd = 2'b00;
  logic [1:0]    ack_wd;
  logic          err_wd, busy_wd, start_wd, we_wd;
  logic [10:0]   x0_wd, y0_wd, px_wd, py_wd;
  logic [CW-1:0] col_wd;
  logic [10:0]   stub_xy = '0;
  logic          stub_done = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  square_draw_arbiter #(.SIZE(SIZE), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .x0_0(x0_0), .y0_0(y0_0), .x0_1(x0_1), .y0_1(y0_1),
    .col_0(col_0), .col_1(col_1),
    .ack(ack), .err(err), .busy(busy), .drw_start(drw_start),
    .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x(d_x), .drw_y(d_y), .drw_done(d_done),
    .pix_x(pix_x), .pix_y(pix_y), .pix_col(pix_col), .pix_we(pix_we)
  );

  square_draw_arbiter #(.SIZE(SIZE), .CW(CW), .TIMEOUT(20)) dut_wd (
    .clk(clk), .reset(reset), .req(req_wd),
    .x0_0(x0_0), .y0_0(y0_0), .x0_1(x0_1), .y0_1(y0_1),
    .col_0(col_0), .col_1(col_1),
    .ack(ack_wd), .err(err_wd), .busy(busy_wd), .drw_start(start_wd),
    .drw_x0(x0_wd), .drw_y0(y0_wd), .drw_x(stub_xy), .drw_y(stub_xy), .drw_done(stub_done),
    .pix_x(px_wd), .pix_y(py_wd), .pix_col(col_wd), .pix_we(we_wd)
  );

  // Drawer model: rasters x inner, y outer; holds done while start stays high.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_active <= 1'b0; d_done <= 1'b0; d_x <= '0; d_y <= '0;
    end else if (!drw_start) begin
      d_active <= 1'b0; d_done <= 1'b0;
    end else if (!d_active && !d_done) begin
      d_active <= 1'b1; d_x <= drw_x0; d_y <= drw_y0;
    end else if (d_active) begin
      if (d_x == 11'(drw_x0 + 11'(SIZE))) begin
        if (d_y == 11'(drw_y0 + 11'(SIZE))) begin
          d_active <= 1'b0; d_done <= 1'b1;
        end else begin
          d_x <= drw_x0; d_y <= d_y + 11'd1;
        end
      end else begin
        d_x <= d_x + 11'd1;
      end
    end
  end

  int          we_cnt, col_bad, n_ack, n_job;
  logic        new_job, auto_drop;
  logic [10:0] last_x, last_y;
  logic [CW-1:0] exp_col;
  int          ack_cyc [8];
  logic [1:0]  ack_val [8];
  logic        ack_start [8];
  logic [10:0] job_fx [8], job_fy [8];
  logic [CW-1:0] job_col [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_mon();
    we_cnt = 0; col_bad = 0; n_ack = 0; n_job = 0; new_job = 1'b1;
    last_x = '0; last_y = '0;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (pix_we) begin
        if (new_job) begin
          if (n_job < 8) begin
            job_fx[n_job] = pix_x; job_fy[n_job] = pix_y; job_col[n_job] = pix_col;
          end
          n_job++;
          new_job = 1'b0;
        end
        we_cnt++;
        last_x = pix_x; last_y = pix_y;
        if (pix_col !== exp_col) col_bad++;
      end
      if (ack != 2'b00) begin
        if (n_ack < 8) begin
          ack_cyc[n_ack] = cyc; ack_val[n_ack] = ack; ack_start[n_ack] = drw_start;
        end
        n_ack++;
        new_job = 1'b1;
        if (auto_drop) req = req & ~ack;
      end
    end
  endtask

  initial begin
    int t0, t1, wd_we, wd_early;
    auto_drop = 1'b1;
    exp_col   = '0;
    clr_mon();

    // Reset values
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_start", drw_start, 0);
    chk("rst_we", pix_we, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_x0y0", {drw_x0, drw_y0}, 0);
    chk("rst_col", pix_col, 0);

    // Single job from requester 0 at (20,20), colour 5
    reset = 1'b0;
    req = 2'b01; x0_0 = 11'd20; y0_0 = 11'd20; col_0 = 3'd5; exp_col = 3'd5;
    t0 = cyc;
    step();
    chk("a_issue_start", drw_start, 1);
    chk("a_issue_busy", busy, 1);
    clr_mon();
    watch(123);
    chk("a_we_cnt", we_cnt, 121);
    chk("a_first_x", job_fx[0], 20);
    chk("a_first_y", job_fy[0], 20);
    chk("a_last_x", last_x, 30);
    chk("a_last_y", last_y, 30);
    chk("a_col_bad", col_bad, 0);
    chk("a_n_ack", n_ack, 1);
    chk("a_ack_val", ack_val[0], 2'b01);
    chk("a_ack_lat", ack_cyc[0] - t0, 124);
    chk("a_ack_start", ack_start[0], 0);
    step();
    chk("a_idle_busy", busy, 0);

    // Both requesting continuously from reset: 0,1,0,1 back to back
    reset = 1'b1; step();
    reset = 1'b0;
    req = 2'b11; x0_0 = 11'd0; y0_0 = 11'd0; col_0 = 3'd1;
    x0_1 = 11'd100; y0_1 = 11'd50; col_1 = 3'd6;
    auto_drop = 1'b0;
    t0 = cyc;
    step();
    clr_mon();
    watch(495);
    req = 2'b00;
    chk("b_n_ack", n_ack, 4);
    chk("b_ack0", ack_val[0], 2'b01);
    chk("b_ack1", ack_val[1], 2'b10);
    chk("b_ack2", ack_val[2], 2'b01);
    chk("b_ack3", ack_val[3], 2'b10);
    chk("b_lat0", ack_cyc[0] - t0, 124);
    chk("b_period1", ack_cyc[1] - ack_cyc[0], 124);
    chk("b_period3", ack_cyc[3] - ack_cyc[2], 124);
    chk("b_we_cnt", we_cnt, 484);
    chk("b_job0_org", {job_fx[0], job_fy[0]}, {11'd0, 11'd0});
    chk("b_job1_org", {job_fx[1], job_fy[1]}, {11'd100, 11'd50});
    chk("b_job1_col", job_col[1], 6);
    chk("b_job2_col", job_col[2], 1);
    step();
    chk("b_idle_busy", busy, 0);

    // Requester 0 re-requests through its ack while requester 1 is idle
    req = 2'b01; x0_0 = 11'd5; y0_0 = 11'd9; col_0 = 3'd3; exp_col = 3'd3;
    t0 = cyc;
    step();
    clr_mon();
    watch(123);
    chk("c_ack_lat", ack_cyc[0] - t0, 124);
    chk("c_ack_val", ack, 2'b01);
    step();
    chk("c_no_regrant_busy", busy, 0);
    chk("c_no_regrant_start", drw_start, 0);
    t1 = cyc;
    step();
    chk("c_regrant_start", drw_start, 1);
    chk("c_regrant_x0", drw_x0, 5);

    // Requester 0 drops req mid-draw; job still completes
    clr_mon();
    watch(10);
    req = 2'b00;
    watch(113);
    chk("d_we_cnt", we_cnt, 121);
    chk("d_n_ack", n_ack, 1);
    chk("d_ack_val", ack_val[0], 2'b01);
    chk("d_ack_lat", ack_cyc[0] - t1, 124);
    chk("d_col_bad", col_bad, 0);
    step();

    // Reset asserted at pixel 60 of a job
    auto_drop = 1'b1;
    req = 2'b01; x0_0 = 11'd40; y0_0 = 11'd40; col_0 = 3'd7; exp_col = 3'd7;
    step();
    clr_mon();
    watch(60);
    chk("e_we_cnt", we_cnt, 60);
    chk("e_pix60", {last_x, last_y}, {11'd44, 11'd45});
    reset = 1'b1; req = 2'b00;
    step();
    chk("e_rst_ctrl", {busy, drw_start, pix_we, ack, err}, 0);
    chk("e_rst_org", {drw_x0, drw_y0}, 0);
    chk("e_rst_pix", {pix_x, pix_y, pix_col}, 0);
    reset = 1'b0;
    clr_mon();
    watch(5);
    chk("e_no_ack", n_ack, 0);
    chk("e_no_we", we_cnt, 0);
    req = 2'b01; x0_0 = 11'd7; y0_0 = 11'd3; col_0 = 3'd2; exp_col = 3'd2;
    t0 = cyc;
    step();
    chk("e_new_x0", drw_x0, 7);
    clr_mon();
    watch(123);
    chk("e_new_org", {job_fx[0], job_fy[0]}, {11'd7, 11'd3});
    chk("e_new_last", {last_x, last_y}, {11'd17, 11'd13});
    chk("e_new_we", we_cnt, 121);
    chk("e_new_col_bad", col_bad, 0);
    chk("e_new_ack_lat", ack_cyc[0] - t0, 124);
    step();

    // Watchdog with a drawer that never finishes, TIMEOUT = 20
    req_wd = 2'b01;
    step();
    chk("w_issue_start", start_wd, 1);
    wd_we = 0; wd_early = 0;
    for (int i = 0; i < 21; i++) begin
      step();
      if (we_wd) wd_we++;
      if (err_wd || ack_wd != 2'b00) wd_early++;
    end
    chk("w_draw_cycles", wd_we, 21);
    chk("w_no_early", wd_early, 0);
    step();
    chk("w_err", err_wd, 1);
    chk("w_ack", ack_wd, 2'b01);
    chk("w_rel_start", start_wd, 0);
    req_wd = 2'b00;
    step();
    chk("w_idle_busy", busy_wd, 0);
    chk("w_err_pulse", err_wd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/square_draw_arbiter.md
# square_draw_arbiter

Shares a single `square_drawer` instance between two requesters, for example the moving-object painter and the eraser. Each requester posts a square origin and a colour. The arbiter picks one with round-robin priority and latches its job. It then sequences the drawer through its start/done handshake and merges the drawer's pixel stream with the latched colour into one frame-buffer write port. A watchdog aborts any job whose drawer never reports done.

## Interface
Parameters:
- `SIZE`, default 10: forwarded to the drawer. Each job writes (SIZE+1)² pixels.
- `CW`, default 3: colour width in bits.
- `TIMEOUT`, default 4095: maximum number of DRAW cycles before a job is aborted.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high.
- `req`  in  2: per-requester draw request. A requester holds its bit high until it sees its `ack` bit.
- `x0_0`, `y0_0`, `x0_1`, `y0_1`  in  11 each: square origin for requester 0 and requester 1.
- `col_0`, `col_1`  in  CW each: fill colour for requester 0 and requester 1.
- `ack`  out  2: one-cycle completion pulse, per requester.
- `err`  out  1: one-cycle pulse when a job hits the watchdog timeout.
- `busy`  out  1: high whenever the state is not IDLE.
- `drw_start`  out  1: drives the drawer's `start`.
- `drw_x0`, `drw_y0`  out  11 each: latched origin sent to the drawer.
- `drw_x`, `drw_y`  in  11 each: the drawer's current pixel coordinate.
- `drw_done`  in  1: the drawer's `done`.
- `pix_x`, `pix_y`  out  11 each: frame-buffer write address.
- `pix_col`  out  CW: frame-buffer write data.
- `pix_we`  out  1: frame-buffer write enable.

## Operation
- State machine with four states: IDLE, ISSUE, DRAW, RELEASE.
- IDLE:
  - If any `req` bit is high, grant one requester using round robin. The winner is the first requester after `last`, where `last` is the index of the previously served requester.
  - On the grant edge, latch the requester's index into `gnt`, its origin into `drw_x0`/`drw_y0`, and its colour into a colour register. Move to ISSUE.
- ISSUE: assert `drw_start`. Clear the watchdog counter. Move to DRAW unconditionally.
- DRAW:
  - Keep `drw_start` = 1.
  - Drive `pix_we` = !`drw_done`.
  - Increment the watchdog counter every cycle.
  - If `drw_done` = 1, move to RELEASE.
  - Otherwise, if the counter equals TIMEOUT, pulse `err` and move to RELEASE.
- RELEASE:
  - Drive `drw_start` = 0. The drawer sees start low and returns to idle on the next edge.
  - Pulse `ack[gnt]`, set `last` <= `gnt`.
  - Re-arbitrate with requester `gnt` masked out. If the other requester is requesting, grant it and move directly to ISSUE; otherwise move to IDLE.
- Latched origin and colour stay constant from the grant edge until the next grant. The drawer depends on a stable `x0`/`y0`.
- Pixel address `pix_x`/`pix_y` = `drw_x`/`drw_y`, combinational pass-through. `pix_col` = the latched colour.
- A requester that drops `req` before it is granted is simply never served. Dropping `req` after the grant has no effect: the job runs to completion and `ack` still pulses.
- The watchdog counter is wide enough to hold TIMEOUT (12 bits at the default). It saturates and does not wrap.

## Timing
- Reset values: state = IDLE, `last` = 1 (so requester 0 wins the first contest), `gnt` = 0, colour register = 0, counter = 0.
- Outputs under reset: `drw_x0` = `drw_y0` = 0, `drw_start` = `pix_we` = `ack` = `err` = `busy` = 0.
- Reset asserted mid-job:
  - Return to IDLE on the next edge.
  - Emit no `ack`.
  - The drawer is reset by the same `reset` and must not be left in its finish state.
- Latency, where request `req` is first seen high in IDLE at cycle t:
  - ISSUE at t+1.
  - `pix_we` high for exactly (SIZE+1)² consecutive cycles, t+2 to t+(SIZE+1)²+1.
  - One DRAW cycle with `drw_done` = 1 and `pix_we` = 0.
  - `ack` in RELEASE at t+(SIZE+1)²+3. At SIZE = 10: pixels at t+2 to t+122, ack at t+124.
- Back-to-back jobs (RELEASE to ISSUE): job period is (SIZE+1)²+3 cycles, which is 124 at SIZE = 10.
- Simultaneous requests: served alternately. Neither requester waits more than one job.
- `busy` = (state != IDLE).

## Test plan
- Reset, then `req` = 01 with origin (20,20) and `col_0` = 5:
  - exactly 121 `pix_we` cycles;
  - first pixel (20,20), last pixel (30,30), every write has `pix_col` = 5;
  - `ack` = 01 at t+124; `drw_start` low in the RELEASE cycle.
- `req` = 11 held continuously, origins (0,0) and (100,50):
  - grant order 0, 1, 0, 1;
  - second job's ISSUE immediately follows the first job's RELEASE, giving a period of 124 cycles.
- Requester 0 re-requests right after its ack while requester 1 is idle:
  - not re-granted in the RELEASE cycle;
  - granted from IDLE one cycle later.
- Requester 0 drops `req` during DRAW: job still completes all 121 writes and `ack[0]` pulses.
- Hold `drw_done` = 0 (drawer stubbed) with TIMEOUT = 20:
  - `err` pulses after 20 DRAW cycles;
  - `ack` pulses in the same RELEASE cycle;
  - the arbiter returns to IDLE.
- Assert `reset` at pixel 60 of a job:
  - all outputs 0 on the next cycle;
  - no `ack`;
  - a new request afterwards starts cleanly at its origin.
